// File: rtl/ex_stage_if.sv
// ID/EX inputs, forwarding paths and EX/MEM outputs of the execute stage, bundled for port hookup.
// The master modport drives the ID/EX side; the slave modport belongs to ex_stage.
interface ex_stage_if #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
);
  logic [WORD_W-1:0] npc, jaddr, rdata1, rdata2, extout;
  logic              branch, dren, dwen, regwrite, regdst, halt;
  logic [1:0]        memtoreg, alusrc;
  logic [3:0]        aluop;
  logic [REG_W-1:0]  rd, rt;
  logic [1:0]        fwd_a, fwd_b;
  logic [WORD_W-1:0] mem_fwd, wb_fwd;

  logic              br_taken;
  logic [WORD_W-1:0] br_target;
  logic [WORD_W-1:0] em_alu, em_wdata, em_npc;
  logic [REG_W-1:0]  em_waddr;
  logic [1:0]        em_memtoreg;
  logic              em_dren, em_dwen, em_regwrite, em_halt, em_valid, em_ovf;

  modport master (
    output npc, jaddr, rdata1, rdata2, extout, branch, dren, dwen, regwrite, regdst, halt,
           memtoreg, alusrc, aluop, rd, rt, fwd_a, fwd_b, mem_fwd, wb_fwd,
    input  br_taken, br_target, em_alu, em_wdata, em_npc, em_waddr, em_memtoreg,
           em_dren, em_dwen, em_regwrite, em_halt, em_valid, em_ovf
  );

  modport slave (
    input  npc, jaddr, rdata1, rdata2, extout, branch, dren, dwen, regwrite, regdst, halt,
           memtoreg, alusrc, aluop, rd, rt, fwd_a, fwd_b, mem_fwd, wb_fwd,
    output br_taken, br_target, em_alu, em_wdata, em_npc, em_waddr, em_memtoreg,
           em_dren, em_dwen, em_regwrite, em_halt, em_valid, em_ovf
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution and the EX/MEM register.
// Optional EX_OVF_TRAP_EN: signed ADD/SUB overflow sets em_ovf and suppresses regwrite.
module ex_stage #(
  parameter int WORD_W   = 32,
  parameter int REG_W    = 5,
  parameter int LINK_REG = 31
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ex_en,
  input  logic       ex_flush,
  ex_stage_if.slave  bus
);
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0, ALU_SRL = 4'd1, ALU_ADD = 4'd2, ALU_SUB = 4'd3,
    ALU_AND  = 4'd4, ALU_OR  = 4'd5, ALU_XOR = 4'd6, ALU_NOR = 4'd7,
    ALU_SLT  = 4'd8, ALU_SLTU = 4'd9
  } aluop_t;

  typedef struct packed {
    word_t     alu;
    word_t     wdata;
    word_t     npc;
    regbits_t  waddr;
    logic [1:0] memtoreg;
    logic      dren;
    logic      dwen;
    logic      regwrite;
    logic      halt;
    logic      valid;
    logic      ovf;
  } em_t;

  word_t    op_a, op_b, store_val, sum, diff, result;
  regbits_t waddr;
  logic     ovf;
  em_t      em_d, em_q;

  // The jump address is resolved upstream; it only passes through the ID/EX bundle.
  logic unused_jaddr;
  assign unused_jaddr = ^bus.jaddr;

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    op_a = bus.rdata1;
    if (bus.fwd_a == 2'b01)      op_a = bus.mem_fwd;
    else if (bus.fwd_a == 2'b10) op_a = bus.wb_fwd;

    store_val = bus.rdata2;
    if (bus.fwd_b == 2'b01)      store_val = bus.mem_fwd;
    else if (bus.fwd_b == 2'b10) store_val = bus.wb_fwd;

    case (bus.alusrc)
      2'b00:   op_b = store_val;
      2'b01:   op_b = bus.extout;
      2'b10:   op_b = bus.extout << 16;
      default: op_b = '0;
    endcase
  end

  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;

  always_comb begin
    result = '0;
    case (bus.aluop)
      ALU_SLL:  result = op_b << op_a[4:0];
      ALU_SRL:  result = op_b >> op_a[4:0];
      ALU_ADD:  result = sum;
      ALU_SUB:  result = diff;
      ALU_AND:  result = op_a & op_b;
      ALU_OR:   result = op_a | op_b;
      ALU_XOR:  result = op_a ^ op_b;
      ALU_NOR:  result = ~(op_a | op_b);
      ALU_SLT:  result = {{(WORD_W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: result = {{(WORD_W-1){1'b0}}, op_a < op_b};
      default:  result = '0;
    endcase
  end

`ifdef EX_OVF_TRAP_EN
  always_comb begin
    ovf = 1'b0;
    if (bus.aluop == ALU_ADD)
      ovf = (op_a[WORD_W-1] == op_b[WORD_W-1]) && (sum[WORD_W-1] != op_a[WORD_W-1]);
    else if (bus.aluop == ALU_SUB)
      ovf = (op_a[WORD_W-1] != op_b[WORD_W-1]) && (diff[WORD_W-1] != op_a[WORD_W-1]);
  end
`else
  assign ovf = 1'b0;
`endif

  assign waddr         = (bus.memtoreg == 2'b10) ? regbits_t'(LINK_REG)
                                                 : (bus.regdst ? bus.rd : bus.rt);
  assign bus.br_taken  = bus.branch && (result == '0);
  assign bus.br_target = bus.npc + (bus.extout << 2);

  // A captured halt freezes the entry; only flush or reset release it.
  always_comb begin
    em_d = em_q;
    if (ex_flush) begin
      em_d = '0;
    end else if (!em_q.halt && ex_en) begin
      em_d.alu      = result;
      em_d.wdata    = store_val;
      em_d.npc      = bus.npc;
      em_d.waddr    = waddr;
      em_d.memtoreg = bus.memtoreg;
      em_d.dren     = bus.dren;
      em_d.dwen     = bus.dwen;
      em_d.regwrite = bus.regwrite && !ovf;
      em_d.halt     = bus.halt;
      em_d.valid    = 1'b1;
      em_d.ovf      = ovf;
    end
  end

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) em_q <= '0;
    else     em_q <= em_d;
  end

  assign bus.em_alu      = em_q.alu;
  assign bus.em_wdata    = em_q.wdata;
  assign bus.em_npc      = em_q.npc;
  assign bus.em_waddr    = em_q.waddr;
  assign bus.em_memtoreg = em_q.memtoreg;
  assign bus.em_dren     = em_q.dren;
  assign bus.em_dwen     = em_q.dwen;
  assign bus.em_regwrite = em_q.regwrite;
  assign bus.em_halt     = em_q.halt;
  assign bus.em_valid    = em_q.valid;
  assign bus.em_ovf      = em_q.ovf;
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed literal cases plus randomized traffic against
// a behavioural model of the EX/MEM entry and branch outputs.
module tb_ex_stage;
  logic CLK = 1'b0;
  logic RST, ex_en, ex_flush;
  int   checks = 0;
  int   failures = 0;

  ex_stage_if bus ();

  ex_stage dut (
    .CLK      (CLK),
    .RST      (RST),
    .ex_en    (ex_en),
    .ex_flush (ex_flush),
    .bus      (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] alu, wdata, npc;
    logic [4:0]  waddr;
    logic [1:0]  memtoreg;
    logic        dren, dwen, regwrite, halt, valid, ovf;
  } em_m_t;

  em_m_t model;
  logic  model_ok = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_val);
    if (sel == 2'd1) return bus.mem_fwd;
    if (sel == 2'd2) return bus.wb_fwd;
    return reg_val;
  endfunction

  // Predicts the ALU result and overflow from the inputs currently on the bus.
  function automatic void alu_model(output logic [31:0] res, output logic ovf);
    logic [31:0] a, b;
    longint      sa, sb, wide;
    a = pick(bus.fwd_a, bus.rdata1);
    case (bus.alusrc)
      2'd0: b = pick(bus.fwd_b, bus.rdata2);
      2'd1: b = bus.extout;
      2'd2: b = bus.extout * 32'd65536;
      default: b = 32'd0;
    endcase
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    wide = 0;
    case (bus.aluop)
      4'd0: res = b << a[4:0];
      4'd1: res = b >> a[4:0];
      4'd2: begin wide = sa + sb; res = 32'(wide); end
      4'd3: begin wide = sa - sb; res = 32'(wide); end
      4'd4: res = a & b;
      4'd5: res = a | b;
      4'd6: res = a ^ b;
      4'd7: res = ~(a | b);
      4'd8: res = (sa < sb) ? 32'd1 : 32'd0;
      4'd9: res = (a < b) ? 32'd1 : 32'd0;
      default: res = 32'd0;
    endcase
`ifdef EX_OVF_TRAP_EN
    ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
`else
    ovf = 1'b0;
`endif
  endfunction

  function automatic em_m_t predict();
    em_m_t       e;
    logic [31:0] r;
    logic        o;
    alu_model(r, o);
    e.alu      = r;
    e.wdata    = pick(bus.fwd_b, bus.rdata2);
    e.npc      = bus.npc;
    e.waddr    = (bus.memtoreg == 2'b10) ? 5'd31 : (bus.regdst ? bus.rd : bus.rt);
    e.memtoreg = bus.memtoreg;
    e.dren     = bus.dren;
    e.dwen     = bus.dwen;
    e.regwrite = bus.regwrite & ~o;
    e.halt     = bus.halt;
    e.valid    = 1'b1;
    e.ovf      = o;
    return e;
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      model    <= '0;
      model_ok <= 1'b1;
    end else if (ex_flush) begin
      model <= '0;
    end else if (!model.halt && ex_en) begin
      model <= predict();
    end
  end

  // Compare every cycle on the falling edge, away from the capturing edge.
  always @(negedge CLK) begin
    logic [31:0] r;
    logic        o;
    if (model_ok) begin
      alu_model(r, o);
      check("br_taken",    32'(bus.br_taken),    32'(bus.branch && (r == 32'd0)));
      check("br_target",   bus.br_target,        bus.npc + bus.extout * 32'd4);
      check("em_alu",      bus.em_alu,           model.alu);
      check("em_wdata",    bus.em_wdata,         model.wdata);
      check("em_npc",      bus.em_npc,           model.npc);
      check("em_waddr",    32'(bus.em_waddr),    32'(model.waddr));
      check("em_memtoreg", 32'(bus.em_memtoreg), 32'(model.memtoreg));
      check("em_dren",     32'(bus.em_dren),     32'(model.dren));
      check("em_dwen",     32'(bus.em_dwen),     32'(model.dwen));
      check("em_regwrite", 32'(bus.em_regwrite), 32'(model.regwrite));
      check("em_halt",     32'(bus.em_halt),     32'(model.halt));
      check("em_valid",    32'(bus.em_valid),    32'(model.valid));
      check("em_ovf",      32'(bus.em_ovf),      32'(model.ovf));
    end
  end

  task automatic clear_inputs();
    bus.npc = '0; bus.jaddr = '0; bus.rdata1 = '0; bus.rdata2 = '0; bus.extout = '0;
    bus.branch = 0; bus.dren = 0; bus.dwen = 0; bus.regwrite = 0; bus.regdst = 0; bus.halt = 0;
    bus.memtoreg = '0; bus.alusrc = '0; bus.aluop = '0; bus.rd = '0; bus.rt = '0;
    bus.fwd_a = '0; bus.fwd_b = '0; bus.mem_fwd = '0; bus.wb_fwd = '0;
    ex_en = 1'b1; ex_flush = 1'b0;
  endtask

  task automatic rand_inputs();
    bus.npc = $urandom; bus.jaddr = $urandom; bus.rdata1 = $urandom;
    bus.rdata2 = ($urandom_range(3) == 0) ? bus.rdata1 : $urandom;
    bus.extout = ($urandom_range(1) == 0) ? $urandom_range(65535) : $urandom;
    bus.mem_fwd = $urandom; bus.wb_fwd = ($urandom_range(3) == 0) ? bus.rdata1 : $urandom;
    bus.branch = 1'($urandom); bus.dren = 1'($urandom); bus.dwen = 1'($urandom);
    bus.regwrite = 1'($urandom); bus.regdst = 1'($urandom);
    bus.halt = ($urandom_range(63) == 0);
    bus.memtoreg = 2'($urandom); bus.alusrc = 2'($urandom); bus.aluop = 4'($urandom);
    bus.rd = 5'($urandom); bus.rt = 5'($urandom);
    bus.fwd_a = 2'($urandom); bus.fwd_b = 2'($urandom);
    ex_en = ($urandom_range(3) != 0);
    ex_flush = ($urandom_range(15) == 0);
    RST = ($urandom_range(199) == 0);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    clear_inputs();
    step(); step();
    check("rst_valid", 32'(bus.em_valid), 32'd0);
    check("rst_alu",   bus.em_alu,        32'd0);
    check("rst_halt",  32'(bus.em_halt),  32'd0);

    RST = 1'b0;
    bus.rdata1 = 5; bus.extout = 7; bus.alusrc = 2'b01; bus.aluop = 4'd2;
    bus.regdst = 0; bus.rt = 9; bus.regwrite = 1;
    step();
    check("add_alu",   bus.em_alu,            32'd12);
    check("add_waddr", 32'(bus.em_waddr),     32'd9);
    check("add_rw",    32'(bus.em_regwrite),  32'd1);
    check("add_valid", 32'(bus.em_valid),     32'd1);

    clear_inputs();
    bus.fwd_a = 2'b01; bus.mem_fwd = 32'h10; bus.rdata1 = 32'hDEAD; bus.aluop = 4'd3;
    bus.alusrc = 2'b00; bus.rdata2 = 32'h10; bus.branch = 1; bus.npc = 32'h100; bus.extout = 4;
    bus.regwrite = 1;
    #1;
    check("fwd_br_taken",  32'(bus.br_taken), 32'd1);
    check("fwd_br_target", bus.br_target,     32'h110);
    step();
    check("fwd_alu",   bus.em_alu,   32'd0);
    check("fwd_wdata", bus.em_wdata, 32'h10);

    ex_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.rdata1 = $urandom; bus.aluop = 4'd5; bus.npc = $urandom;
      step();
      check("stall_alu",   bus.em_alu,       32'd0);
      check("stall_npc",   bus.em_npc,       32'h100);
      check("stall_valid", 32'(bus.em_valid), 32'd1);
    end
    ex_flush = 1'b1;
    step();
    check("flush_valid", 32'(bus.em_valid),    32'd0);
    check("flush_rw",    32'(bus.em_regwrite), 32'd0);

    clear_inputs();
    bus.memtoreg = 2'b10; bus.regdst = 1; bus.rd = 4; bus.rt = 7;
    step();
    check("link_waddr", 32'(bus.em_waddr), 32'd31);
    clear_inputs();
    bus.alusrc = 2'b10; bus.extout = 32'h1234; bus.aluop = 4'd5; bus.rdata1 = 0;
    step();
    check("lui_alu", bus.em_alu, 32'h12340000);

    clear_inputs();
    bus.halt = 1; bus.aluop = 4'd2; bus.rdata1 = 1; bus.extout = 2; bus.alusrc = 2'b01;
    step();
    check("halt_cap", 32'(bus.em_halt), 32'd1);
    for (int i = 0; i < 4; i++) begin
      bus.halt = 0; bus.rdata1 = $urandom; bus.aluop = 4'($urandom_range(9));
      step();
      check("halt_hold",     32'(bus.em_halt), 32'd1);
      check("halt_hold_alu", bus.em_alu,       32'd3);
    end
    RST = 1'b1;
    step();
    check("halt_rst_halt",  32'(bus.em_halt),  32'd0);
    check("halt_rst_alu",   bus.em_alu,        32'd0);
    check("halt_rst_valid", 32'(bus.em_valid), 32'd0);
    RST = 1'b0;
    bus.halt = 1;
    step();
    ex_flush = 1'b1; bus.halt = 0;
    step();
    check("halt_flush", 32'(bus.em_halt), 32'd0);

    clear_inputs();
    bus.rdata1 = 32'h7FFFFFFF; bus.extout = 1; bus.alusrc = 2'b01; bus.aluop = 4'd2; bus.regwrite = 1;
    step();
    check("ovf_alu", bus.em_alu, 32'h80000000);
`ifdef EX_OVF_TRAP_EN
    check("ovf_flag", 32'(bus.em_ovf),      32'd1);
    check("ovf_rw",   32'(bus.em_regwrite), 32'd0);
`else
    check("ovf_flag", 32'(bus.em_ovf),      32'd0);
    check("ovf_rw",   32'(bus.em_regwrite), 32'd1);
`endif

    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      step();
    end

    RST = 1'b0;
    @(negedge CLK);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
